// File: rtl/rega_controlador_if.sv
// rtl/rega_controlador_if.sv - raw sensor inputs and display/plant outputs of rega_controlador
interface rega_controlador_if;
    logic H_in;
    logic M_in;
    logic L_in;
    logic Solo_in;
    logic Temp_in;
    logic H;
    logic M;
    logic L;
    logic Bs;
    logic Vs;
    logic Sd;
    logic Ve;
    logic Alarme;

    modport master (
        output H_in, M_in, L_in, Solo_in, Temp_in,
        input  H, M, L, Bs, Vs, Sd, Ve, Alarme
    );

    modport slave (
        input  H_in, M_in, L_in, Solo_in, Temp_in,
        output H, M, L, Bs, Vs, Sd, Ve, Alarme
    );
endinterface

// File: rtl/rega_controlador.sv
// rtl/rega_controlador.sv - irrigation controller: sensor conditioning, run FSM, fill valve
// Optional debouncers selected by REGA_DEBOUNCE_EN; without it the filtered flags are the synchronizer outputs.
module rega_controlador #(
    parameter int DEB_CYCLES   = 4,
    parameter int MIN_ON       = 8,
    parameter int PAUSE_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    rega_controlador_if.slave io_bus
);
    localparam int CH_H    = 4;
    localparam int CH_M    = 3;
    localparam int CH_L    = 2;
    localparam int CH_SOLO = 1;
    localparam int CH_TEMP = 0;
    localparam int RUN_MAX = (MIN_ON > PAUSE_CYCLES) ? MIN_ON : PAUSE_CYCLES;
    localparam int CNT_NEED = (DEB_CYCLES > RUN_MAX) ? DEB_CYCLES : RUN_MAX;

    if ((CNT_NEED >> CNT_W) != 0) begin : g_cnt_w_too_narrow
        $error("CNT_W cannot hold the largest cycle count");
    end

    typedef enum logic [2:0] {S_IDLE, S_ASP, S_GOT, S_PAUSE, S_FAULT} state_t;

    logic [4:0] w_raw;
    logic [4:0] r_sync1;
    logic [4:0] r_sync2;
    logic [4:0] w_filt;

    assign w_raw = {io_bus.H_in, io_bus.M_in, io_bus.L_in, io_bus.Solo_in, io_bus.Temp_in};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
        end
    end

`ifdef REGA_DEBOUNCE_EN
    logic [4:0]       r_filt;
    logic [CNT_W-1:0] r_deb_cnt [5];

    // A channel flips only after DEB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (!rst_n) begin
                r_filt[i]    <= 1'b0;
                r_deb_cnt[i] <= '0;
            end else if (r_sync2[i] == r_filt[i]) begin
                r_deb_cnt[i] <= '0;
            end else if (r_deb_cnt[i] == CNT_W'(DEB_CYCLES - 1)) begin
                r_filt[i]    <= r_sync2[i];
                r_deb_cnt[i] <= '0;
            end else begin
                r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
            end
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = r_sync2;
`endif

    logic w_h, w_m, w_l, w_solo, w_temp;
    logic w_invalid, w_run_done, w_pause_done;
    state_t r_state, w_next;
    logic [CNT_W-1:0] r_cnt;

    assign w_h          = w_filt[CH_H];
    assign w_m          = w_filt[CH_M];
    assign w_l          = w_filt[CH_L];
    assign w_solo       = w_filt[CH_SOLO];
    assign w_temp       = w_filt[CH_TEMP];
    assign w_invalid    = (w_h & ~w_m) | (w_m & ~w_l);
    assign w_run_done   = ~w_solo & (r_cnt >= CNT_W'(MIN_ON - 1));
    assign w_pause_done = (r_cnt == CNT_W'(PAUSE_CYCLES - 1));

    // Priority inside each state: fault, then water cutoff, then soil-wet exit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_invalid)                    w_next = S_FAULT;
                else if (w_solo & w_temp & w_m)   w_next = S_ASP;
                else if (w_solo & ~w_temp & w_l)  w_next = S_GOT;
            end
            S_ASP: begin
                if (w_invalid)                    w_next = S_FAULT;
                else if (~w_m)                    w_next = S_PAUSE;
                else if (w_run_done)              w_next = S_PAUSE;
            end
            S_GOT: begin
                if (w_invalid)                    w_next = S_FAULT;
                else if (~w_l)                    w_next = S_PAUSE;
                else if (w_run_done)              w_next = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_invalid)                    w_next = S_FAULT;
                else if (w_pause_done)            w_next = S_IDLE;
            end
            S_FAULT: begin
                if (~w_invalid)                   w_next = S_PAUSE;
            end
            default:                              w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state)  r_cnt <= '0;
            else if (r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
        end
    end

    logic r_bs, r_vs, r_sd, r_alarme, r_ve;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_bs     <= 1'b0;
            r_vs     <= 1'b0;
            r_sd     <= 1'b0;
            r_alarme <= 1'b0;
            r_ve     <= 1'b0;
        end else begin
            r_bs     <= (w_next == S_ASP);
            r_vs     <= (w_next == S_GOT);
            r_sd     <= (w_next == S_ASP) || (w_next == S_GOT);
            r_alarme <= (w_next == S_FAULT);
            if (w_next == S_FAULT) r_ve <= 1'b0;
            else if (~w_l)         r_ve <= 1'b1;
            else if (w_h)          r_ve <= 1'b0;
        end
    end

    assign io_bus.H      = w_h;
    assign io_bus.M      = w_m;
    assign io_bus.L      = w_l;
    assign io_bus.Bs     = r_bs;
    assign io_bus.Vs     = r_vs;
    assign io_bus.Sd     = r_sd;
    assign io_bus.Ve     = r_ve;
    assign io_bus.Alarme = r_alarme;
endmodule

// File: tb/tb_rega_controlador.sv
// tb/tb_rega_controlador.sv - self-checking bench for rega_controlador (directed timing plus random vs reference model)
module tb_rega_controlador;
    localparam int DEB_CYCLES   = 4;
    localparam int MIN_ON       = 8;
    localparam int PAUSE_CYCLES = 4;
    localparam int CNT_W        = 8;
`ifdef REGA_DEBOUNCE_EN
    localparam int LAT    = DEB_CYCLES + 2;
    localparam bit DEB_ON = 1'b1;
`else
    localparam int LAT    = 2;
    localparam bit DEB_ON = 1'b0;
`endif
    localparam int ST_IDLE = 0, ST_ASP = 1, ST_GOT = 2, ST_PAUSE = 3, ST_FAULT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    rega_controlador_if io();

    rega_controlador #(
        .DEB_CYCLES  (DEB_CYCLES),
        .MIN_ON      (MIN_ON),
        .PAUSE_CYCLES(PAUSE_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io_bus(io)
    );

    always #5 clk = ~clk;

    logic [7:0] obs;
    assign obs = {io.H, io.M, io.L, io.Bs, io.Vs, io.Sd, io.Ve, io.Alarme};

    // Reference model: window-based filtering, rule-list FSM, time-in-state counter.
    logic [4:0] m_s1 = '0;
    logic [4:0] m_s2 = '0;
    logic [4:0] m_f  = '0;
    logic [4:0] m_hist [$];
    int         m_st    = ST_IDLE;
    int         m_since = 0;
    logic       m_ve    = 1'b0;
    logic [7:0] m_out   = '0;

    always @(posedge clk) begin : ref_model
        logic [4:0] f_new;
        logic h, m, l, solo, temp, inval;
        int nxt;
        bit all_flip;
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_f = '0;
            m_hist.delete();
            m_st = ST_IDLE; m_since = 0; m_ve = 1'b0;
        end else begin
            {h, m, l, solo, temp} = m_f;
            inval = (h && !m) || (m && !l);
            nxt = m_st;
            case (m_st)
                ST_IDLE:  if (inval) nxt = ST_FAULT;
                          else if (solo && temp && m) nxt = ST_ASP;
                          else if (solo && !temp && l) nxt = ST_GOT;
                ST_ASP:   if (inval) nxt = ST_FAULT;
                          else if (!m) nxt = ST_PAUSE;
                          else if (!solo && m_since >= MIN_ON - 1) nxt = ST_PAUSE;
                ST_GOT:   if (inval) nxt = ST_FAULT;
                          else if (!l) nxt = ST_PAUSE;
                          else if (!solo && m_since >= MIN_ON - 1) nxt = ST_PAUSE;
                ST_PAUSE: if (inval) nxt = ST_FAULT;
                          else if (m_since == PAUSE_CYCLES - 1) nxt = ST_IDLE;
                default:  if (!inval) nxt = ST_PAUSE;
            endcase
            if (nxt == ST_FAULT) m_ve = 1'b0;
            else if (!l)         m_ve = 1'b1;
            else if (h)          m_ve = 1'b0;
            m_since = (nxt != m_st) ? 0 : m_since + 1;
            m_st = nxt;

            m_hist.push_back(m_s2);
            if (m_hist.size() > DEB_CYCLES) void'(m_hist.pop_front());
            f_new = m_f;
            if (DEB_ON) begin
                for (int c = 0; c < 5; c++) begin
                    all_flip = (m_hist.size() == DEB_CYCLES);
                    foreach (m_hist[k]) if (m_hist[k][c] == m_f[c]) all_flip = 0;
                    if (all_flip) f_new[c] = ~m_f[c];
                end
            end else begin
                f_new = m_s1;
            end
            m_f  = f_new;
            m_s2 = m_s1;
            m_s1 = {io.H_in, io.M_in, io.L_in, io.Solo_in, io.Temp_in};
        end
        m_out = {m_f[4], m_f[3], m_f[2], m_st == ST_ASP, m_st == ST_GOT,
                 (m_st == ST_ASP) || (m_st == ST_GOT), m_ve, m_st == ST_FAULT};
    end

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_raw(input logic h, input logic m, input logic l, input logic s, input logic t);
        io.H_in = h; io.M_in = m; io.L_in = l; io.Solo_in = s; io.Temp_in = t;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        set_raw(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        repeat (3) tick();
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL reset_outputs got=%b want=%b", obs, 8'h00); end
    endtask

    task automatic test_fill;
        set_raw(1, 1, 1, 0, 0);
        rst_n = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            if (e == 1) begin
                checks++;
                if (io.Ve !== 1'b1) begin errors++; $display("FAIL fill_ve_rise got=%b want=1", io.Ve); end
            end
            if (e == LAT - 1) begin
                checks++;
                if ({io.H, io.M, io.L} !== 3'b000) begin errors++; $display("FAIL fill_levels_early got=%b want=000", {io.H, io.M, io.L}); end
            end
            if (e == LAT) begin
                checks++;
                if ({io.H, io.M, io.L} !== 3'b111) begin errors++; $display("FAIL fill_levels got=%b want=111", {io.H, io.M, io.L}); end
            end
            if (e == LAT + 1) begin
                checks++;
                if (io.Ve !== 1'b0) begin errors++; $display("FAIL fill_ve_fall got=%b want=0", io.Ve); end
            end
        end
        checks++;
        if ({io.Bs, io.Vs, io.Sd, io.Alarme} !== 4'b0000) begin errors++; $display("FAIL fill_no_irrigation got=%b want=0000", {io.Bs, io.Vs, io.Sd, io.Alarme}); end
    endtask

    task automatic test_sprinkler;
        int len, gap, exp_len, exp_gap;
        exp_len = (MIN_ON > LAT + 3) ? MIN_ON : LAT + 3;
        exp_gap = (PAUSE_CYCLES + 1 > LAT + 1) ? PAUSE_CYCLES + 1 : LAT + 1;
        set_raw(1, 1, 1, 1, 1);
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            if (e == LAT) begin
                checks++;
                if (io.Bs !== 1'b0) begin errors++; $display("FAIL asp_early got=%b want=0", io.Bs); end
            end
            if (e == LAT + 1) begin
                checks++;
                if ({io.Bs, io.Vs, io.Sd} !== 3'b101) begin errors++; $display("FAIL asp_start got=%b want=101", {io.Bs, io.Vs, io.Sd}); end
            end
        end
        tick(); tick();
        len = 3;
        set_raw(1, 1, 1, 0, 1);
        while (len < 100) begin
            tick();
            if (io.Sd === 1'b1) len++;
            else break;
        end
        checks++;
        if (len != exp_len) begin errors++; $display("FAIL asp_run_length got=%0d want=%0d", len, exp_len); end
        set_raw(1, 1, 1, 1, 1);
        gap = 1;
        while (gap < 50) begin
            tick();
            if (io.Sd === 1'b0) gap++;
            else break;
        end
        checks++;
        if (gap != exp_gap || io.Bs !== 1'b1) begin errors++; $display("FAIL asp_gap got=%0d bs=%b want=%0d bs=1", gap, io.Bs, exp_gap); end
    endtask

    task automatic test_drip_cutoff;
        int w;
        do_reset();
        set_raw(1, 1, 1, 0, 0);
        repeat (LAT + 2) tick();
        set_raw(1, 1, 1, 1, 0);
        w = 0;
        while (io.Vs !== 1'b1 && w < 40) begin tick(); w++; end
        checks++;
        if (io.Vs !== 1'b1 || w != LAT + 1) begin errors++; $display("FAIL got_start vs=%b after=%0d want vs=1 after=%0d", io.Vs, w, LAT + 1); end
        repeat (3) tick();
        set_raw(0, 0, 0, 1, 0);
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            if (e == LAT) begin
                checks++;
                if (io.Vs !== 1'b1) begin errors++; $display("FAIL got_cutoff_early got=%b want=1", io.Vs); end
            end
            if (e == LAT + 1) begin
                checks++;
                if ({io.Vs, io.Sd, io.Ve} !== 3'b001) begin errors++; $display("FAIL got_cutoff vs_sd_ve got=%b want=001", {io.Vs, io.Sd, io.Ve}); end
            end
        end
    endtask

    task automatic test_fault;
        int w, gap;
        do_reset();
        set_raw(1, 1, 1, 1, 1);
        w = 0;
        while (io.Bs !== 1'b1 && w < 40) begin tick(); w++; end
        checks++;
        if (io.Bs !== 1'b1) begin errors++; $display("FAIL fault_run_start got=%b want=1", io.Bs); end
        set_raw(1, 0, 1, 1, 1);
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            if (e == LAT) begin
                checks++;
                if (io.Alarme !== 1'b0) begin errors++; $display("FAIL fault_early got=%b want=0", io.Alarme); end
            end
            if (e == LAT + 1) begin
                checks++;
                if ({io.Alarme, io.Bs, io.Sd, io.Ve} !== 4'b1000) begin errors++; $display("FAIL fault_entry alarme_bs_sd_ve got=%b want=1000", {io.Alarme, io.Bs, io.Sd, io.Ve}); end
            end
        end
        set_raw(1, 1, 1, 1, 1);
        for (int e = 1; e <= LAT + 1; e++) tick();
        checks++;
        if (io.Alarme !== 1'b0) begin errors++; $display("FAIL fault_clear got=%b want=0", io.Alarme); end
        gap = 1;
        while (gap < 50) begin
            tick();
            if (io.Sd === 1'b0) gap++;
            else break;
        end
        checks++;
        if (gap != PAUSE_CYCLES + 1) begin errors++; $display("FAIL fault_pause_gap got=%0d want=%0d", gap, PAUSE_CYCLES + 1); end
    endtask

    task automatic test_glitch;
        int first_sd, exp_first;
        exp_first = DEB_ON ? 0 : 3;
        do_reset();
        set_raw(1, 1, 1, 0, 1);
        repeat (LAT + 2) tick();
        first_sd = 0;
        set_raw(1, 1, 1, 1, 1);
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (e == 3) set_raw(1, 1, 1, 0, 1);
            if (io.Sd === 1'b1 && first_sd == 0) first_sd = e;
        end
        checks++;
        if (first_sd != exp_first) begin errors++; $display("FAIL glitch_sd_edge got=%0d want=%0d", first_sd, exp_first); end
    endtask

    task automatic test_reset_mid_run;
        int w;
        do_reset();
        set_raw(1, 1, 1, 1, 1);
        w = 0;
        while (io.Bs !== 1'b1 && w < 40) begin tick(); w++; end
        tick(); tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (obs !== 8'h00) begin errors++; $display("FAIL midrun_reset got=%b want=%b", obs, 8'h00); end
        rst_n = 1'b1;
        for (int e = 1; e <= LAT + 1; e++) begin
            tick();
            if (e == 1) begin
                checks++;
                if ({io.Bs, io.Ve} !== 2'b01) begin errors++; $display("FAIL midrun_restart bs_ve got=%b want=01", {io.Bs, io.Ve}); end
            end
            if (e == LAT + 1) begin
                checks++;
                if (io.Bs !== 1'b1) begin errors++; $display("FAIL midrun_rerun got=%b want=1", io.Bs); end
            end
        end
    endtask

    task automatic test_random;
        logic [2:0] lvl;
        int hold, n, pick;
        logic [2:0] valid_lvl [4];
        logic [2:0] bad_lvl   [4];
        valid_lvl[0] = 3'b000; valid_lvl[1] = 3'b001; valid_lvl[2] = 3'b011; valid_lvl[3] = 3'b111;
        bad_lvl[0]   = 3'b100; bad_lvl[1]   = 3'b101; bad_lvl[2]   = 3'b110; bad_lvl[3]   = 3'b010;
        do_reset();
        n = 0;
        while (n < 1500) begin
            pick = int'($urandom_range(0, 9));
            lvl  = (pick < 9) ? valid_lvl[$urandom_range(0, 3)] : bad_lvl[$urandom_range(0, 3)];
            set_raw(lvl[2], lvl[1], lvl[0], 1'($urandom), 1'($urandom));
            hold = int'($urandom_range(1, 14));
            for (int k = 0; k < hold; k++) begin
                rst_n = ($urandom_range(0, 299) != 0);
                tick();
                n++;
                checks++;
                if (obs !== m_out) begin
                    errors++;
                    if (errors < 20) $display("FAIL random_cycle%0d got=%b want=%b", n, obs, m_out);
                end
                checks++;
                if ((io.Bs & io.Vs) !== 1'b0 || io.Sd !== (io.Bs | io.Vs)) begin
                    errors++;
                    if (errors < 20) $display("FAIL random_exclusive cycle%0d bs_vs_sd got=%b want=no overlap", n, {io.Bs, io.Vs, io.Sd});
                end
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        set_raw(0, 0, 0, 0, 0);
        rst_n = 1'b0;
        test_reset();
        test_fill();
        test_sprinkler();
        test_drip_cutoff();
        test_fault();
        test_glitch();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
